// File: rtl/z80_ir_pkg.sv
// Shared definitions for the instruction register / prefix sequencer and its bench.
package z80_ir_pkg;

  typedef enum logic [2:0] {XX, CB, ED, IXCB_D, IXCB_OP} ir_state_e;

  typedef enum logic [2:0] {BYTE_OTHER, BYTE_DD, BYTE_FD, BYTE_CB, BYTE_ED} byte_cls_e;

  localparam logic [7:0] OP_DD = 8'hDD;
  localparam logic [7:0] OP_FD = 8'hFD;
  localparam logic [7:0] OP_CB = 8'hCB;
  localparam logic [7:0] OP_ED = 8'hED;

  localparam int PFX_IXY0 = 4;
  localparam int PFX_IXY1 = 3;
  localparam int PFX_XX   = 2;
  localparam int PFX_CB   = 1;
  localparam int PFX_ED   = 0;

  function automatic byte_cls_e classify_byte(input logic [7:0] b);
    case (b)
      OP_DD:   return BYTE_DD;
      OP_FD:   return BYTE_FD;
      OP_CB:   return BYTE_CB;
      OP_ED:   return BYTE_ED;
      default: return BYTE_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/ir_prefix_seq.sv
// Instruction register and DD/FD/CB/ED prefix sequencer feeding pla_decode.
// All outputs are registered; strobes take effect on the sampling edge.
module ir_prefix_seq
  import z80_ir_pkg::*;
#(
  parameter logic [7:0] NOP_OPCODE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] db,
  input  logic       ir_we,
  input  logic       ir_nop,
  input  logic       instr_end,
  output logic [7:0] ir,
  output logic [4:0] prefix,
  output logic [7:0] disp,
  output logic       iy_sel,
  output logic       prefix_fetch,
  output logic       ixcb_phase
);

  ir_state_e   state_q, state_d;
  logic        ixy_q, ixy_d;
  logic        iy_sel_q, iy_sel_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  disp_q, disp_d;
  logic [4:0]  prefix_q, prefix_d;
  logic        pf_q, pf_d;
  logic        ixcb_q, ixcb_d;

  // state/ixy as seen by an incoming byte after instr_end has been applied
  ir_state_e   dec_state;
  logic        dec_ixy;

  always_comb begin
    state_d   = state_q;
    ixy_d     = ixy_q;
    iy_sel_d  = iy_sel_q;
    ir_d      = ir_q;
    disp_d    = disp_q;
    pf_d      = 1'b0;
    dec_state = state_q;
    dec_ixy   = ixy_q;

    if (ir_nop) begin
      ir_d     = NOP_OPCODE;
      state_d  = XX;
      ixy_d    = 1'b0;
      iy_sel_d = 1'b0;
    end else begin
      if (instr_end) begin
        state_d   = XX;
        ixy_d     = 1'b0;
        iy_sel_d  = 1'b0;
        dec_state = XX;
        dec_ixy   = 1'b0;
      end
      if (ir_we) begin
        case (dec_state)
          XX: begin
            case (classify_byte(db))
              BYTE_DD, BYTE_FD: begin
                ixy_d    = 1'b1;
                iy_sel_d = (classify_byte(db) == BYTE_FD);
                ir_d     = NOP_OPCODE;
                pf_d     = 1'b1;
              end
              BYTE_CB: begin
                ir_d    = NOP_OPCODE;
                pf_d    = 1'b1;
                state_d = dec_ixy ? IXCB_D : CB;
              end
              BYTE_ED: begin
                ir_d    = NOP_OPCODE;
                pf_d    = 1'b1;
                state_d = ED;
              end
              default: ir_d = db;
            endcase
          end
          IXCB_D: begin
            disp_d  = db;
            state_d = IXCB_OP;
          end
          default: ir_d = db;
        endcase
      end
    end

    prefix_d           = '0;
    prefix_d[PFX_IXY0] = ~ixy_d;
    prefix_d[PFX_IXY1] = ixy_d;
    prefix_d[PFX_XX]   = (state_d == XX);
    prefix_d[PFX_CB]   = (state_d == CB) || (state_d == IXCB_D) || (state_d == IXCB_OP);
    prefix_d[PFX_ED]   = (state_d == ED);
    ixcb_d             = (state_d == IXCB_D) || (state_d == IXCB_OP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= XX;
      ixy_q    <= 1'b0;
      iy_sel_q <= 1'b0;
      ir_q     <= NOP_OPCODE;
      disp_q   <= 8'h00;
      prefix_q <= 5'b10100;
      pf_q     <= 1'b0;
      ixcb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ixy_q    <= ixy_d;
      iy_sel_q <= iy_sel_d;
      ir_q     <= ir_d;
      disp_q   <= disp_d;
      prefix_q <= prefix_d;
      pf_q     <= pf_d;
      ixcb_q   <= ixcb_d;
    end
  end

  assign ir           = ir_q;
  assign prefix       = prefix_q;
  assign disp         = disp_q;
  assign iy_sel       = iy_sel_q;
  assign prefix_fetch = pf_q;
  assign ixcb_phase   = ixcb_q;

endmodule

// File: tb/tb_ir_prefix_seq.sv
// Bench for ir_prefix_seq: directed test-plan sequences plus randomized
// strobe/byte streams checked against a behavioural model.
module tb_ir_prefix_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] db;
  logic       ir_we, ir_nop, instr_end;
  logic [7:0] ir;
  logic [4:0] prefix;
  logic [7:0] disp;
  logic       iy_sel, prefix_fetch, ixcb_phase;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ir_prefix_seq dut (
    .clk(clk), .reset(reset), .db(db), .ir_we(ir_we), .ir_nop(ir_nop),
    .instr_end(instr_end), .ir(ir), .prefix(prefix), .disp(disp),
    .iy_sel(iy_sel), .prefix_fetch(prefix_fetch), .ixcb_phase(ixcb_phase)
  );

  // observed vector: {ir, prefix, disp, iy_sel, prefix_fetch, ixcb_phase}
  logic [23:0] obs;
  assign obs = {ir, prefix, disp, iy_sel, prefix_fetch, ixcb_phase};

  // ---------------- behavioural model ----------------
  localparam int M_XX = 0, M_CB = 1, M_ED = 2, M_IXD = 3, M_IXOP = 4;
  int         m_mode;
  bit         m_idx, m_iy, m_pf;
  logic [7:0] m_ir, m_disp;

  function automatic logic [23:0] model_vec();
    logic [4:0] p;
    p = {!m_idx, m_idx, m_mode == M_XX,
         (m_mode == M_CB) || (m_mode == M_IXD) || (m_mode == M_IXOP), m_mode == M_ED};
    return {m_ir, p, m_disp, m_iy, m_pf, (m_mode == M_IXD) || (m_mode == M_IXOP)};
  endfunction

  task automatic model_reset();
    m_mode = M_XX; m_idx = 0; m_iy = 0; m_pf = 0; m_ir = 8'h00; m_disp = 8'h00;
  endtask

  task automatic model_step(input bit we, input logic [7:0] b, input bit nop, input bit ie);
    m_pf = 0;
    if (nop) begin
      m_ir = 8'h00; m_mode = M_XX; m_idx = 0; m_iy = 0;
      return;
    end
    if (ie) begin
      m_mode = M_XX; m_idx = 0; m_iy = 0;
    end
    if (!we) return;
    if (m_mode == M_XX) begin
      if (b == 8'hDD || b == 8'hFD) begin
        m_idx = 1; m_iy = (b == 8'hFD); m_ir = 8'h00; m_pf = 1;
      end else if (b == 8'hCB) begin
        m_ir = 8'h00; m_pf = 1; m_mode = m_idx ? M_IXD : M_CB;
      end else if (b == 8'hED) begin
        m_ir = 8'h00; m_pf = 1; m_mode = M_ED;
      end else m_ir = b;
    end else if (m_mode == M_IXD) begin
      m_disp = b; m_mode = M_IXOP;
    end else m_ir = b;
  endtask

  // one clock with the given strobes; returns #1 after the sampling edge
  task automatic cyc(input bit we, input logic [7:0] b, input bit nop, input bit ie);
    @(negedge clk);
    ir_we = we; db = b; ir_nop = nop; instr_end = ie;
    model_step(we, b, nop, ie);
    @(posedge clk);
    #1;
    ir_we = 0; ir_nop = 0; instr_end = 0; db = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  // stimulus row: {we, nop, ie, db}
  task automatic run_table(input string name, input logic [10:0] stim[], input logic [23:0] expv[]);
    for (int i = 0; i < stim.size(); i++) begin
      cyc(stim[i][10], stim[i][7:0], stim[i][9], stim[i][8]);
      n_tests++;
      if (obs !== expv[i]) begin
        n_fail++;
        $display("FAIL %s step %0d: got ir/pfx/disp/iy/pf/ixcb=%h/%b/%h/%b/%b/%b want %h/%b/%h/%b/%b/%b",
                 name, i, obs[23:16], obs[15:11], obs[10:3], obs[2], obs[1], obs[0],
                 expv[i][23:16], expv[i][15:11], expv[i][10:3], expv[i][2], expv[i][1], expv[i][0]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs !== {8'h00, 5'b10100, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, {8'h00, 5'b10100, 8'h00, 3'b000});
    end
  endtask

  task automatic test_plain();
    run_table("plain_3e",
      '{{3'b100, 8'h3E}, {3'b001, 8'h00}, {3'b000, 8'h00}},
      '{{8'h3E, 5'b10100, 8'h00, 3'b000},
        {8'h3E, 5'b10100, 8'h00, 3'b000},
        {8'h3E, 5'b10100, 8'h00, 3'b000}});
  endtask

  task automatic test_dd_prefix();
    run_table("dd_21",
      '{{3'b100, 8'hDD}, {3'b100, 8'h21}, {3'b001, 8'h00}},
      '{{8'h00, 5'b01100, 8'h00, 3'b010},
        {8'h21, 5'b01100, 8'h00, 3'b000},
        {8'h21, 5'b10100, 8'h00, 3'b000}});
  endtask

  task automatic test_ed_ed();
    run_table("ed_ed",
      '{{3'b100, 8'hED}, {3'b100, 8'hED}, {3'b001, 8'h00}},
      '{{8'h00, 5'b10001, 8'h00, 3'b010},
        {8'hED, 5'b10001, 8'h00, 3'b000},
        {8'hED, 5'b10100, 8'h00, 3'b000}});
  endtask

  task automatic test_dd_nop();
    // DD then forced NOP; then NOP together with a DD strobe discards the byte
    run_table("dd_nop",
      '{{3'b100, 8'hDD}, {3'b010, 8'h00}, {3'b110, 8'hDD}, {3'b100, 8'hDD}, {3'b100, 8'hFD}},
      '{{8'h00, 5'b01100, 8'h00, 3'b010},
        {8'h00, 5'b10100, 8'h00, 3'b000},
        {8'h00, 5'b10100, 8'h00, 3'b000},
        {8'h00, 5'b01100, 8'h00, 3'b010},
        {8'h00, 5'b01100, 8'h00, 3'b110}});
  endtask

  task automatic test_end_with_we();
    run_table("end_with_dd",
      '{{3'b001, 8'h00}, {3'b100, 8'h3E}, {3'b101, 8'hDD}, {3'b100, 8'h2A}, {3'b001, 8'h00}},
      '{{8'h00, 5'b10100, 8'h00, 3'b000},
        {8'h3E, 5'b10100, 8'h00, 3'b000},
        {8'h00, 5'b01100, 8'h00, 3'b010},
        {8'h2A, 5'b01100, 8'h00, 3'b000},
        {8'h2A, 5'b10100, 8'h00, 3'b000}});
  endtask

  task automatic test_fd_cb();
    run_table("fdcb_05_46",
      '{{3'b100, 8'hFD}, {3'b100, 8'hCB}, {3'b100, 8'h05}, {3'b100, 8'h46}, {3'b001, 8'h00}},
      '{{8'h00, 5'b01100, 8'h00, 3'b110},
        {8'h00, 5'b01010, 8'h00, 3'b111},
        {8'h00, 5'b01010, 8'h05, 3'b101},
        {8'h46, 5'b01010, 8'h05, 3'b101},
        {8'h46, 5'b10100, 8'h05, 3'b000}});
  endtask

  task automatic test_async_reset();
    cyc(1, 8'hDD, 0, 0);
    cyc(1, 8'hCB, 0, 0);
    n_tests++;
    if (ixcb_phase !== 1'b1) begin
      n_fail++;
      $display("FAIL ixcb_entry: got ixcb_phase=%b want 1", ixcb_phase);
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    n_tests++;
    if (obs !== {8'h00, 5'b10100, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs, {8'h00, 5'b10100, 8'h00, 3'b000});
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit we, nop, ie;
    int r;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hDD;
        1: b = 8'hFD;
        2, 3: b = 8'hCB;
        4: b = 8'hED;
        default: b = 8'($urandom);
      endcase
      we  = ($urandom_range(0, 99) < 60);
      ie  = ($urandom_range(0, 99) < 15);
      nop = ($urandom_range(0, 99) < 4);
      cyc(we, b, nop, ie);
      n_tests++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d (we=%b db=%h nop=%b end=%b): got %h want %h",
                 i, we, b, nop, ie, obs, model_vec());
      end
    end
  endtask

  initial begin
    reset = 1; db = 8'h00; ir_we = 0; ir_nop = 0; instr_end = 0;
    model_reset();
    test_reset();
    test_plain();
    test_dd_prefix();
    test_ed_ed();
    test_dd_nop();
    test_end_with_we();
    test_fd_cb();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
